// File: rtl/compress42_pkg.sv
// Shared types and helpers for the carry-save 4:2 accumulator.
// The ADD state is used only when COMPRESS42_FINAL_ADD_EN is defined.
package compress42_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ADD} state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SEG   = 32;

  function automatic int seg_count(input int width, input int seg);
    return width / seg;
  endfunction
endpackage

// File: rtl/compress42_accum_if.sv
// Beat input / result output bundle for compress42_accum.
// out_sum exists only when COMPRESS42_FINAL_ADD_EN is defined.
interface compress42_accum_if #(
  parameter int WIDTH  = 64,
  parameter int BEAT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_s;
  logic [WIDTH-1:0]  out_c;
  logic [BEAT_W-1:0] out_beats;
`ifdef COMPRESS42_FINAL_ADD_EN
  logic [WIDTH-1:0]  out_sum;
`endif

  modport master (
    output in_valid, in_first, in_last, in_a, in_b, out_ready,
`ifdef COMPRESS42_FINAL_ADD_EN
    input  out_sum,
`endif
    input  in_ready, out_valid, out_s, out_c, out_beats
  );

  modport slave (
    input  in_valid, in_first, in_last, in_a, in_b, out_ready,
`ifdef COMPRESS42_FINAL_ADD_EN
    output out_sum,
`endif
    output in_ready, out_valid, out_s, out_c, out_beats
  );
endinterface

// File: rtl/compress42_seg.sv
// SEG-bit 4:2 compressor segment, combinational. Bit i's carry c[i] has weight 2^(i+1);
// the intra-segment horizontal carry enters at cin and leaves at cout.
module compress42_seg #(
  parameter int SEG = 32
) (
  input  logic [SEG-1:0] x1,
  input  logic [SEG-1:0] x2,
  input  logic [SEG-1:0] x3,
  input  logic [SEG-1:0] x4,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic [SEG-1:0] c,
  output logic           cout
);
  logic [SEG-1:0] s1, h, hin;

  // First full-adder row; its majority output ripples one bit left, independent of cin,
  // so the chain across segments is only one level deep per segment.
  assign s1   = x1 ^ x2 ^ x3;
  assign h    = (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign hin  = {h[SEG-2:0], cin};
  assign cout = h[SEG-1];

  assign s = s1 ^ x4 ^ hin;
  assign c = (s1 & x4) | (s1 & hin) | (x4 & hin);
endmodule

// File: rtl/compress42_accum.sv
// Iterative carry-save accumulator: folds row pairs into (acc_s, acc_c) with a chained 4:2 compressor.
// Define COMPRESS42_FINAL_ADD_EN to add a registered carry-propagate out_sum (one extra cycle).
module compress42_accum
  import compress42_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SEG    = DEF_SEG,
  parameter int BEAT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  compress42_accum_if.slave  bus
);
  localparam int NSEG = seg_count(WIDTH, SEG);

  generate
    if (WIDTH % SEG != 0) begin : g_bad_seg
      $error("compress42_accum: WIDTH must be a multiple of SEG");
    end
  endgenerate

  state_t            state;
  logic [WIDTH-1:0]  acc_s, acc_c;
  logic [BEAT_W-1:0] cnt;
  logic              in_ready_q, out_valid_q;
  logic [WIDTH-1:0]  out_s_q, out_c_q;
  logic [BEAT_W-1:0] out_beats_q;

  logic              accept, first_beat;
  logic [WIDTH-1:0]  op_s, op_c, comp_s, comp_c, new_c;
  logic [NSEG:0]     chain;
  logic [BEAT_W-1:0] cnt_nxt;

  assign accept     = bus.in_valid && in_ready_q;
  assign first_beat = (state == IDLE) || bus.in_first;
  assign op_s       = first_beat ? '0 : acc_s;
  assign op_c       = first_beat ? '0 : acc_c;
  assign chain[0]   = 1'b0;

  genvar g;
  generate
    for (g = 0; g < NSEG; g++) begin : g_seg
      compress42_seg #(.SEG(SEG)) u_seg (
        .x1   (op_s[g*SEG +: SEG]),
        .x2   (op_c[g*SEG +: SEG]),
        .x3   (bus.in_a[g*SEG +: SEG]),
        .x4   (bus.in_b[g*SEG +: SEG]),
        .cin  (chain[g]),
        .s    (comp_s[g*SEG +: SEG]),
        .c    (comp_c[g*SEG +: SEG]),
        .cout (chain[g+1])
      );
    end
  endgenerate

  // chain[NSEG] is the top carry-out; it falls outside mod 2^WIDTH and is dropped.
  assign new_c   = {comp_c[WIDTH-2:0], 1'b0};
  assign cnt_nxt = first_beat ? BEAT_W'(1) : ((&cnt) ? cnt : cnt + BEAT_W'(1));

`ifdef COMPRESS42_FINAL_ADD_EN
  logic [WIDTH-1:0] out_sum_q;
  assign bus.out_sum = out_sum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_s       <= '0;
      acc_c       <= '0;
      cnt         <= '0;
      out_s_q     <= '0;
      out_c_q     <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef COMPRESS42_FINAL_ADD_EN
      out_sum_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_s <= comp_s;
            acc_c <= new_c;
            cnt   <= cnt_nxt;
            if (bus.in_last) begin
              out_s_q     <= comp_s;
              out_c_q     <= new_c;
              out_beats_q <= cnt_nxt;
              in_ready_q  <= 1'b0;
`ifdef COMPRESS42_FINAL_ADD_EN
              state       <= ADD;
`else
              state       <= DONE;
              out_valid_q <= 1'b1;
`endif
            end else begin
              state <= ACCUM;
            end
          end
        end
`ifdef COMPRESS42_FINAL_ADD_EN
        ADD: begin
          out_sum_q   <= out_s_q + out_c_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_beats = out_beats_q;
endmodule
